// File: rtl/decode_uop_queue_pkg.sv
// Shared control-signal types for the decode/issue micro-op queue.
package ctrl_sigs;

  localparam int unsigned UOPQ_DEPTH_DEFAULT = 8;
  localparam int unsigned UOPQ_ENQ_W_DEFAULT = 2;
  localparam int unsigned UOPQ_DEQ_W_DEFAULT = 2;

  // 50-bit decoded micro-op; taken marks a predicted-taken branch
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  opcode;
    logic [4:0]  rd;
    logic [3:0]  fu;
    logic        taken;
  } queue_item_t;

endpackage

// File: rtl/decode_uop_queue_compactor.sv
// Packs valid enqueue lanes into consecutive slots, cutting off lanes younger
// than the first taken branch.
module uopq_compactor #(
  parameter  int unsigned ENQ_W = 2,
  localparam int unsigned OFF_W = (ENQ_W > 1) ? $clog2(ENQ_W) : 1,
  localparam int unsigned NW    = $clog2(ENQ_W + 1)
) (
  input  logic [ENQ_W-1:0] enq_valid,
  input  logic [ENQ_W-1:0] taken,
  output logic [ENQ_W-1:0] wr_en,
  output logic [OFF_W-1:0] wr_off [ENQ_W],
  output logic [NW-1:0]    n_enq
);

  logic [NW-1:0] cnt;
  logic          stop;

  // running prefix sum over valid lanes, frozen once a taken lane is written
  always_comb begin
    wr_en = '0;
    cnt   = '0;
    stop  = 1'b0;
    for (int i = 0; i < int'(ENQ_W); i++) begin
      wr_off[i] = '0;
      if (enq_valid[i] && !stop) begin
        wr_en[i]  = 1'b1;
        wr_off[i] = OFF_W'(cnt);
        cnt       = NW'(cnt + 1'b1);
        if (taken[i]) stop = 1'b1;
      end
    end
    n_enq = cnt;
  end

endmodule

// File: rtl/decode_uop_queue.sv
// Circular micro-op buffer between decode and issue: multi-lane compacting
// enqueue, in-order multi-lane dequeue window, flush to empty.
module decode_uop_queue
  import ctrl_sigs::*;
#(
  parameter  int unsigned DEPTH  = UOPQ_DEPTH_DEFAULT,
  parameter  int unsigned ENQ_W  = UOPQ_ENQ_W_DEFAULT,
  parameter  int unsigned DEQ_W  = UOPQ_DEQ_W_DEFAULT,
  localparam int unsigned IDX_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned TAKE_W = $clog2(DEQ_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ENQ_W-1:0]  enq_valid,
  input  queue_item_t       enq_item [ENQ_W],
  output logic              enq_ready,
  output logic [DEQ_W-1:0]  deq_valid,
  output queue_item_t       deq_item [DEQ_W],
  input  logic [TAKE_W-1:0] deq_take,
  output logic [CNT_W-1:0]  count
);

  typedef logic [IDX_W-1:0] uopq_idx_t;

  localparam int unsigned OFF_W = (ENQ_W > 1) ? $clog2(ENQ_W) : 1;
  localparam int unsigned NW    = $clog2(ENQ_W + 1);

  queue_item_t      mem [DEPTH];
  uopq_idx_t        head, tail, head_next, tail_next;
  logic [CNT_W-1:0] count_next;

  logic [ENQ_W-1:0] taken;
  logic [ENQ_W-1:0] wr_en;
  logic [OFF_W-1:0] wr_off [ENQ_W];
  logic [NW-1:0]    n_enq, n_wr;
  uopq_idx_t        wr_idx [ENQ_W];
  logic             enq_fire;

  uopq_compactor #(.ENQ_W(ENQ_W)) u_compactor (
    .enq_valid (enq_valid),
    .taken     (taken),
    .wr_en     (wr_en),
    .wr_off    (wr_off),
    .n_enq     (n_enq)
  );

  // next-state pointers; flush wins over any same-cycle enqueue or dequeue
  always_comb begin
    enq_fire   = enq_ready && !flush && (|enq_valid);
    n_wr       = enq_fire ? n_enq : '0;
    head_next  = uopq_idx_t'(head + uopq_idx_t'(deq_take));
    tail_next  = uopq_idx_t'(tail + uopq_idx_t'(n_wr));
    count_next = CNT_W'(count + CNT_W'(n_wr) - CNT_W'(deq_take));
    for (int i = 0; i < int'(ENQ_W); i++) begin
      taken[i]  = enq_item[i].taken;
      wr_idx[i] = uopq_idx_t'(tail + uopq_idx_t'(wr_off[i]));
    end
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  // pointers plus registered status derived from the next occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      enq_ready <= 1'b1;
      deq_valid <= '0;
    end else begin
      head      <= head_next;
      tail      <= tail_next;
      count     <= count_next;
      enq_ready <= (count_next <= CNT_W'(DEPTH - ENQ_W));
      for (int i = 0; i < int'(DEQ_W); i++) begin
        deq_valid[i] <= (count_next > CNT_W'(i));
      end
    end
  end

  // storage holds no reset; occupancy alone defines what is live
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(ENQ_W); i++) begin
      if (!rst && enq_fire && wr_en[i]) mem[wr_idx[i]] <= enq_item[i];
    end
  end

  for (genvar g = 0; g < int'(DEQ_W); g++) begin : g_rd
    uopq_idx_t rd_idx;
    assign rd_idx      = uopq_idx_t'(head + uopq_idx_t'(g));
    assign deq_item[g] = mem[rd_idx];
  end

  deq_take_le_count : assert property (@(posedge clk) disable iff (rst)
    CNT_W'(deq_take) <= count);

endmodule

// File: tb/tb_decode_uop_queue.sv
// Scoreboard bench for decode_uop_queue: directed scenarios then random traffic.
module tb_decode_uop_queue;
  import ctrl_sigs::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned ENQ_W = 2;
  localparam int unsigned DEQ_W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  enq_valid = '0;
  queue_item_t enq_item [ENQ_W];
  logic        enq_ready;
  logic [1:0]  deq_valid;
  queue_item_t deq_item [DEQ_W];
  logic [1:0]  deq_take = '0;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;
  int next_id = 1;
  queue_item_t sb [$];

  always #5 clk = ~clk;

  decode_uop_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_item  (enq_item),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_item  (deq_item),
    .deq_take  (deq_take),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic queue_item_t mk(input bit tk);
    queue_item_t it;
    it.pc     = 32'(next_id);
    it.opcode = 8'($urandom);
    it.rd     = 5'($urandom);
    it.fu     = 4'($urandom);
    it.taken  = tk;
    next_id++;
    return it;
  endfunction

  task automatic check_state(input string tag);
    int n;
    n = sb.size();
    check({tag, "_count"}, 64'(count), 64'(n));
    check({tag, "_ready"}, 64'(enq_ready), 64'(n <= int'(DEPTH - ENQ_W)));
    check({tag, "_dvalid"}, 64'(deq_valid), 64'({n > 1, n > 0}));
    for (int i = 0; i < int'(DEQ_W); i++) begin
      if (i < n) check({tag, "_ditem"}, 64'(deq_item[i]), 64'(sb[i]));
    end
  endtask

  // one clock: apply inputs, retire taken items against the scoreboard, update model
  task automatic step(input logic [1:0] v, input queue_item_t i0, input queue_item_t i1,
                      input int take, input logic fl, input string tag);
    queue_item_t lanes [2];
    queue_item_t exp;
    bit ready;
    lanes[0] = i0;
    lanes[1] = i1;
    enq_valid   = v;
    enq_item[0] = i0;
    enq_item[1] = i1;
    deq_take    = 2'(take);
    flush       = fl;
    ready = (sb.size() <= int'(DEPTH - ENQ_W));
    for (int k = 0; k < take; k++) begin
      exp = sb.pop_front();
      check({tag, "_take"}, 64'(deq_item[k]), 64'(exp));
    end
    if (fl) begin
      sb.delete();
    end else if (ready) begin
      for (int l = 0; l < 2; l++) begin
        if (v[l]) begin
          sb.push_back(lanes[l]);
          if (lanes[l].taken) break;
        end
      end
    end
    @(posedge clk);
    #1;
    enq_valid = '0;
    deq_take  = '0;
    flush     = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input logic fl);
    rst       = 1'b1;
    flush     = fl;
    enq_valid = 2'b11;
    enq_item[0] = mk(1'b0);
    enq_item[1] = mk(1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b0;
    enq_valid = '0;
    sb.delete();
    check("rst_count", 64'(count), 64'(0));
    check("rst_dvalid", 64'(deq_valid), 64'(0));
    check("rst_ready", 64'(enq_ready), 64'(1));
  endtask

  task automatic drain(input string tag);
    while (sb.size() > 0) begin
      step(2'b00, mk(0), mk(0), (sb.size() >= 2) ? 2 : 1, 1'b0, tag);
    end
  endtask

  initial begin
    queue_item_t a, b, c, d, e;
    enq_item[0] = '0;
    enq_item[1] = '0;
    #1;
    do_reset(1'b0);

    // 1: two-lane enqueue visible next cycle
    a = mk(0); b = mk(0);
    step(2'b11, a, b, 0, 1'b0, "t1_enq");
    step(2'b00, mk(0), mk(0), 0, 1'b0, "t1_idle");
    check("t1_count", 64'(count), 64'(2));
    check("t1_item0", 64'(deq_item[0]), 64'(a));
    check("t1_item1", 64'(deq_item[1]), 64'(b));
    drain("t1_drain");

    // 2: lone lane-1 uop compacts to the tail slot
    c = mk(0);
    step(2'b10, mk(0), c, 0, 1'b0, "t2_enq");
    check("t2_count", 64'(count), 64'(1));
    check("t2_item0", 64'(deq_item[0]), 64'(c));
    drain("t2_drain");

    // 3: taken lane 0 discards lane 1
    d = mk(1); e = mk(0);
    step(2'b11, d, e, 0, 1'b0, "t3_enq");
    check("t3_count", 64'(count), 64'(1));
    check("t3_item0", 64'(deq_item[0]), 64'(d));
    drain("t3_drain");

    // 4: near-full refusal, then wrap of the tail
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(2'b11, mk(0), mk(0), 0, 1'b0, "t4_fill");
    step(2'b01, mk(0), mk(0), 0, 1'b0, "t4_fill7");
    check("t4_ready_lo", 64'(enq_ready), 64'(0));
    step(2'b11, mk(0), mk(0), 2, 1'b0, "t4_refuse");
    check("t4_count5", 64'(count), 64'(5));
    step(2'b11, mk(0), mk(0), 0, 1'b0, "t4_wrap");
    check("t4_count7", 64'(count), 64'(7));
    drain("t4_drain");

    // 5: flush overrides same-cycle enqueue and dequeue
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(2'b11, mk(0), mk(0), 0, 1'b0, "t5_pre");
    for (int i = 0; i < 3; i++) step(2'b00, mk(0), mk(0), 2, 1'b0, "t5_adv");
    step(2'b11, mk(0), mk(0), 0, 1'b0, "t5_a");
    step(2'b11, mk(0), mk(0), 0, 1'b0, "t5_b");
    check("t5_count4", 64'(count), 64'(4));
    step(2'b11, mk(0), mk(0), 1, 1'b1, "t5_flush");
    check("t5_count0", 64'(count), 64'(0));
    check("t5_dvalid", 64'(deq_valid), 64'(0));
    check("t5_ready", 64'(enq_ready), 64'(1));

    // reset mid-stream beats a concurrent flush and drops contents
    step(2'b11, mk(0), mk(0), 0, 1'b0, "t6_pre");
    do_reset(1'b1);
    step(2'b00, mk(0), mk(0), 0, 1'b0, "t6_post");

    // random traffic against the scoreboard
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int mx, tk;
      logic fl;
      mx = (sb.size() >= 2) ? 2 : sb.size();
      tk = $urandom_range(mx, 0);
      fl = ($urandom_range(49, 0) == 0);
      step(2'($urandom), mk($urandom_range(3, 0) == 0), mk($urandom_range(3, 0) == 0),
           tk, fl, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
